// File: rtl/im_arb.sv
// Instruction-memory arbiter between fetch and loader/debug; grants are combinational, responses 1 cycle later.
// No queues: a denied requester holds its request; a starved loader is forced through after STARVE_LIMIT cycles.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef EDGE_OPERATE
`define EDGE_OPERATE posedge
`endif

module im_arb #(
  parameter int MEM_ENTRIES  = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   f_req_i,
  input  logic [`PC_SIZE-1:0]    f_addr_i,
  input  logic                   f_flush_i,
  output logic                   f_gnt_o,
  output logic                   f_valid_o,
  output logic [`INSTR_SIZE-1:0] f_data_o,
  input  logic                   l_req_i,
  input  logic                   l_we_i,
  input  logic                   l_lock_i,
  input  logic [`PC_SIZE-1:0]    l_addr_i,
  input  logic [`INSTR_SIZE-1:0] l_data_i,
  output logic                   l_gnt_o,
  output logic                   l_valid_o,
  output logic [`INSTR_SIZE-1:0] l_data_o,
  output logic                   err_o,
  output logic                   im_enable_o,
  output logic                   im_read_o,
  output logic                   im_write_o,
  output logic [`PC_SIZE-1:0]    im_addr_o,
  output logic [`INSTR_SIZE-1:0] im_data_o,
  input  logic [`INSTR_SIZE-1:0] im_data_i
);

  localparam int AW = `PC_SIZE;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] MEM_LIM = AW'(MEM_ENTRIES);
  localparam logic [SW-1:0] SLIM    = SW'(STARVE_LIMIT);

  typedef enum logic {OPEN, LOCKED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic          err_q, err_nxt;
  logic          wr_q, wr_nxt;
  logic          f_ok, l_ok;

  // Word index compared against the memory depth; low two address bits are byte offsets.
  assign f_ok = ({2'b00, f_addr_i[AW-1:2]} < MEM_LIM);
  assign l_ok = ({2'b00, l_addr_i[AW-1:2]} < MEM_LIM);

  always_comb begin
    f_gnt_o    = 1'b0;
    l_gnt_o    = 1'b0;
    state_nxt  = state;
    starve_nxt = starve;
    if (!rst_i) begin
      if (state == LOCKED)
        l_gnt_o = l_req_i;
      else if (l_req_i && starve == SLIM)
        l_gnt_o = 1'b1;
      else if (f_req_i && !f_flush_i)
        f_gnt_o = 1'b1;
      else if (l_req_i)
        l_gnt_o = 1'b1;
    end

    case (state)
      OPEN:    if (l_gnt_o && l_lock_i) state_nxt = LOCKED;
      LOCKED:  if (!l_lock_i) state_nxt = OPEN;
      default: state_nxt = OPEN;
    endcase

    if (l_gnt_o || !l_req_i)
      starve_nxt = '0;
    else if (starve != SLIM)
      starve_nxt = starve + SW'(1);
  end

  always_comb begin
    im_enable_o = 1'b0;
    im_read_o   = 1'b0;
    im_write_o  = 1'b0;
    im_addr_o   = '0;
    im_data_o   = '0;
    owner_nxt   = OWN_NONE;
    err_nxt     = 1'b0;
    wr_nxt      = 1'b0;
    if (f_gnt_o) begin
      im_enable_o = f_ok;
      im_read_o   = 1'b1;
      im_addr_o   = f_addr_i;
      owner_nxt   = OWN_FETCH;
      err_nxt     = !f_ok;
    end else if (l_gnt_o) begin
      im_enable_o = l_ok;
      im_read_o   = !l_we_i;
      im_write_o  = l_we_i;
      im_addr_o   = l_addr_i;
      im_data_o   = l_data_i;
      owner_nxt   = OWN_LOAD;
      err_nxt     = !l_ok;
      wr_nxt      = l_we_i;
    end
  end

  always_ff @(`EDGE_OPERATE clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= OPEN;
      owner  <= OWN_NONE;
      starve <= '0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      starve <= starve_nxt;
      err_q  <= err_nxt;
      wr_q   <= wr_nxt;
    end
  end

  // A flush in the response cycle kills the fetch data returning from the previous grant.
  assign f_valid_o = (owner == OWN_FETCH) && !f_flush_i;
  assign l_valid_o = (owner == OWN_LOAD);
  assign f_data_o  = (f_valid_o && !err_q) ? im_data_i : '0;
  assign l_data_o  = (l_valid_o && !err_q && !wr_q) ? im_data_i : '0;
  assign err_o     = err_q && (f_valid_o || l_valid_o);

endmodule

// File: tb/tb_im_arb.sv
// Directed self-checking bench for im_arb with a synchronous 128-word instruction memory model.
module tb_im_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        f_req_i = 1'b0, f_flush_i = 1'b0;
  logic [31:0] f_addr_i = '0;
  logic        f_gnt_o, f_valid_o;
  logic [31:0] f_data_o;
  logic        l_req_i = 1'b0, l_we_i = 1'b0, l_lock_i = 1'b0;
  logic [31:0] l_addr_i = '0, l_data_i = '0;
  logic        l_gnt_o, l_valid_o;
  logic [31:0] l_data_o;
  logic        err_o, im_enable_o, im_read_o, im_write_o;
  logic [31:0] im_addr_o, im_data_o;
  logic [31:0] im_rdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  im_arb #(.MEM_ENTRIES(128), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_flush_i(f_flush_i),
    .f_gnt_o(f_gnt_o), .f_valid_o(f_valid_o), .f_data_o(f_data_o),
    .l_req_i(l_req_i), .l_we_i(l_we_i), .l_lock_i(l_lock_i),
    .l_addr_i(l_addr_i), .l_data_i(l_data_i),
    .l_gnt_o(l_gnt_o), .l_valid_o(l_valid_o), .l_data_o(l_data_o),
    .err_o(err_o), .im_enable_o(im_enable_o), .im_read_o(im_read_o),
    .im_write_o(im_write_o), .im_addr_o(im_addr_o), .im_data_o(im_data_o),
    .im_data_i(im_rdata)
  );

  // Memory contents: mem[i] = 0xA500_0000 | i, reloaded on every clock edge seen in reset.
  logic [31:0] mem [0:127];
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (im_enable_o) begin
      if (im_write_o) mem[im_addr_o[8:2]] <= im_data_o;
      if (im_read_o)  im_rdata <= mem[im_addr_o[8:2]];
    end
  end

  typedef struct {
    logic f_req, f_flush; logic [31:0] f_addr;
    logic l_req, l_we, l_lock; logic [31:0] l_addr, l_data;
    logic e_fg, e_lg, e_en, e_rd, e_wr; logic [31:0] e_addr, e_wdat;
    logic e_fv, e_lv, e_err; logic [31:0] e_fdat, e_ldat;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    f_req_i = 0; f_flush_i = 0; f_addr_i = 0;
    l_req_i = 0; l_we_i = 0; l_lock_i = 0; l_addr_i = 0; l_data_i = 0;
  endtask

  task automatic drive(input vec_t v);
    f_req_i = v.f_req; f_flush_i = v.f_flush; f_addr_i = v.f_addr;
    l_req_i = v.l_req; l_we_i = v.l_we; l_lock_i = v.l_lock;
    l_addr_i = v.l_addr; l_data_i = v.l_data;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " f_gnt"},  f_gnt_o, 0);
    check({tag, " l_gnt"},  l_gnt_o, 0);
    check({tag, " f_valid"}, f_valid_o, 0);
    check({tag, " l_valid"}, l_valid_o, 0);
    check({tag, " err"},    err_o, 0);
    check({tag, " im_en"},  im_enable_o, 0);
    check({tag, " im_rd"},  im_read_o, 0);
    check({tag, " im_wr"},  im_write_o, 0);
    check({tag, " im_addr"}, im_addr_o, 0);
    check({tag, " f_data"}, f_data_o, 0);
    check({tag, " l_data"}, l_data_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          f_req flush f_addr  l_req we lock l_addr l_data      fg lg en rd wr e_addr e_wdat      fv lv err fdat ldat
    vt[0]  = '{0,0,32'h0,   0,0,0,32'h0,  32'h0,        0,0,0,0,0,32'h0,  32'h0,        0,0,0,32'h0,         32'h0};
    vt[1]  = '{1,0,32'h0,   0,0,0,32'h0,  32'h0,        1,0,1,1,0,32'h0,  32'h0,        1,0,0,32'hA500_0000, 32'h0};
    vt[2]  = '{1,0,32'h4,   0,0,0,32'h0,  32'h0,        1,0,1,1,0,32'h4,  32'h0,        1,0,0,32'hA500_0001, 32'h0};
    vt[3]  = '{1,0,32'h8,   0,0,0,32'h0,  32'h0,        1,0,1,1,0,32'h8,  32'h0,        1,0,0,32'hA500_0002, 32'h0};
    vt[4]  = '{0,0,32'h0,   1,1,0,32'h10, 32'h1234_5678, 0,1,1,0,1,32'h10, 32'h1234_5678, 0,1,0,32'h0,       32'h0};
    vt[5]  = '{0,0,32'h0,   1,0,0,32'h10, 32'h0,        0,1,1,1,0,32'h10, 32'h0,        0,1,0,32'h0,         32'h1234_5678};
    vt[6]  = '{1,0,32'h14,  1,0,0,32'h20, 32'h0,        1,0,1,1,0,32'h14, 32'h0,        1,0,0,32'hA500_0005, 32'h0};
    vt[7]  = '{1,0,32'h200, 0,0,0,32'h0,  32'h0,        1,0,0,1,0,32'h200,32'h0,        1,0,1,32'h0,         32'h0};
    vt[8]  = '{0,0,32'h0,   1,0,0,32'h1FC,32'h0,        0,1,1,1,0,32'h1FC,32'h0,        0,1,0,32'h0,         32'hA500_007F};
    vt[9]  = '{0,0,32'h0,   1,1,0,32'h200,32'hCAFE_F00D, 0,1,0,0,1,32'h200,32'hCAFE_F00D, 0,1,1,32'h0,       32'h0};
    vt[10] = '{1,1,32'h0,   1,0,0,32'h8,  32'h0,        0,1,1,1,0,32'h8,  32'h0,        0,1,0,32'h0,         32'hA500_0002};
    vt[11] = '{1,1,32'h4,   0,0,0,32'h0,  32'h0,        0,0,0,0,0,32'h0,  32'h0,        0,0,0,32'h0,         32'h0};
    vt[12] = '{1,0,32'h10,  0,0,0,32'h0,  32'h0,        1,0,1,1,0,32'h10, 32'h0,        1,0,0,32'h1234_5678, 32'h0};

    // Reset: requests present but every output held low.
    f_req_i = 1; l_req_i = 1; f_addr_i = 32'h4; l_addr_i = 32'h8;
    repeat (3) @(posedge clk_i);
    #1 check_quiet("reset");
    @(negedge clk_i); idle(); rst_i = 0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i); drive(vt[i]); #1;
      check($sformatf("v%0d f_gnt", i),   f_gnt_o, vt[i].e_fg);
      check($sformatf("v%0d l_gnt", i),   l_gnt_o, vt[i].e_lg);
      check($sformatf("v%0d im_en", i),   im_enable_o, vt[i].e_en);
      check($sformatf("v%0d im_rd", i),   im_read_o, vt[i].e_rd);
      check($sformatf("v%0d im_wr", i),   im_write_o, vt[i].e_wr);
      check($sformatf("v%0d im_addr", i), im_addr_o, vt[i].e_addr);
      check($sformatf("v%0d im_data", i), im_data_o, vt[i].e_wdat);
      @(posedge clk_i); #1; idle(); #1;
      check($sformatf("v%0d f_valid", i), f_valid_o, vt[i].e_fv);
      check($sformatf("v%0d l_valid", i), l_valid_o, vt[i].e_lv);
      check($sformatf("v%0d err", i),     err_o, vt[i].e_err);
      check($sformatf("v%0d f_data", i),  f_data_o, vt[i].e_fdat);
      check($sformatf("v%0d l_data", i),  l_data_o, vt[i].e_ldat);
    end

    // Starvation: both request continuously; loader wins every 5th cycle.
    @(negedge clk_i);
    f_req_i = 1; f_addr_i = 32'h0; l_req_i = 1; l_addr_i = 32'h4;
    for (int c = 0; c < 10; c++) begin
      logic exp_l;
      exp_l = (c == 4) || (c == 9);
      #1;
      check($sformatf("starve c%0d f_gnt", c), f_gnt_o, !exp_l);
      check($sformatf("starve c%0d l_gnt", c), l_gnt_o, exp_l);
      @(posedge clk_i); #1;
      check($sformatf("starve c%0d f_valid", c), f_valid_o, !exp_l);
      check($sformatf("starve c%0d l_valid", c), l_valid_o, exp_l);
      check($sformatf("starve c%0d data", c), exp_l ? l_data_o : f_data_o,
            exp_l ? 32'hA500_0001 : 32'hA500_0000);
      @(negedge clk_i);
    end
    idle();

    // Flush in the response cycle kills the fetch response.
    @(negedge clk_i); f_req_i = 1; f_addr_i = 32'h8;
    @(posedge clk_i); #1; f_req_i = 0; f_flush_i = 1; #1;
    check("flush_resp f_valid", f_valid_o, 0);
    check("flush_resp f_data",  f_data_o, 0);
    check("flush_resp f_gnt",   f_gnt_o, 0);
    @(negedge clk_i); idle();

    // Locked write then read while fetch waits.
    @(negedge clk_i);
    l_req_i = 1; l_we_i = 1; l_lock_i = 1; l_addr_i = 32'h10; l_data_i = 32'hDEAD_BEEF; #1;
    check("lock_w l_gnt", l_gnt_o, 1);
    check("lock_w im_wr", im_write_o, 1);
    @(posedge clk_i); #1;
    f_req_i = 1; f_addr_i = 32'h0; l_we_i = 0; l_data_i = 0; #1;
    check("lock_r f_gnt",   f_gnt_o, 0);
    check("lock_r l_gnt",   l_gnt_o, 1);
    check("lock_r l_valid", l_valid_o, 1);
    check("lock_r ack data", l_data_o, 0);
    @(posedge clk_i); #1;
    l_req_i = 0; l_lock_i = 0; #1;
    check("lock_rel f_gnt",   f_gnt_o, 0);
    check("lock_rel l_gnt",   l_gnt_o, 0);
    check("lock_rel im_en",   im_enable_o, 0);
    check("lock_rel l_valid", l_valid_o, 1);
    check("lock_rel l_data",  l_data_o, 32'hDEAD_BEEF);
    @(posedge clk_i); #2;
    check("unlock f_gnt", f_gnt_o, 1);
    @(posedge clk_i); #1; idle(); #1;
    check("unlock f_valid", f_valid_o, 1);
    check("unlock f_data",  f_data_o, 32'hA500_0000);

    // Reset asserted while a fetch response is pending.
    @(negedge clk_i); f_req_i = 1; f_addr_i = 32'h4;
    @(posedge clk_i); #1; rst_i = 1; #1;
    check_quiet("rst_pend");
    #2; rst_i = 0; idle(); #1;
    check("rst_rel f_valid", f_valid_o, 0);
    @(posedge clk_i); #1;
    check("rst_after f_valid", f_valid_o, 0);
    check("rst_after l_valid", l_valid_o, 0);

    // First grant in the first cycle after reset release.
    @(posedge clk_i); #1; rst_i = 1;
    @(negedge clk_i); rst_i = 0; f_req_i = 1; f_addr_i = 32'h8; #1;
    check("first f_gnt", f_gnt_o, 1);
    @(posedge clk_i); #1; idle(); #1;
    check("first f_valid", f_valid_o, 1);
    check("first f_data",  f_data_o, 32'hA500_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
